sram_controller: RTL and testbench

Multi-cycle controller that sequences 32-bit data-memory accesses from the MEM stage onto an external 16-bit asynchronous SRAM. Each word access is split into a low and a high half-word phase. `ready` freezes the pipeline until the access completes. It replaces the single-cycle on-chip data array behind the MEM stage; the MEM stage holds its request stable while `ready` is low.

---
 rtl/sram_controller_if.sv | 20 ++
 rtl/sram_controller.sv | 96 +++++++++
 tb/tb_sram_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: access request, address/store data,
// registered load data and the pipeline-freeze handshake.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Sequences one 32-bit MEM-stage access onto a 16-bit asynchronous SRAM as a
// low then a high half-word phase, each held for PHASE_CYCLES clocks.
module sram_controller #(
    parameter int PHASE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave mem,
    inout  wire  [15:0]      SRAM_DQ,
    output logic [17:0]      SRAM_ADDR,
    output logic             SRAM_WE_N
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        is_write;
    logic [31:0] read_data_q;
    logic        req;
    logic        phase_end;
    logic        drive;
    logic [15:0] dq_out;
    logic        unused_address_bits;

    assign req       = mem.wr_en | mem.rd_en;
    assign phase_end = (cnt == LAST_CNT);
    assign drive     = is_write && ((state == LOW) || (state == HIGH));

    // The op type is latched on entry so mid-access request changes cannot
    // turn a write into a read halfway through.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_write    <= 1'b0;
            read_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= LOW;
                        cnt      <= '0;
                        is_write <= mem.wr_en;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        state <= HIGH;
                        cnt   <= '0;
                        if (!is_write) read_data_q[15:0] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        state <= DONE;
                        cnt   <= '0;
                        if (!is_write) read_data_q[31:16] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        SRAM_ADDR = '0;
        dq_out    = mem.write_data[15:0];
        case (state)
            LOW:  SRAM_ADDR = {mem.address[18:2], 1'b0};
            HIGH: begin
                SRAM_ADDR = {mem.address[18:2], 1'b1};
                dq_out    = mem.write_data[31:16];
            end
            default: ;
        endcase
    end

    assign SRAM_DQ       = drive ? dq_out : 16'bz;
    assign SRAM_WE_N     = ~drive;
    assign mem.ready     = (state == DONE) || ((state == IDLE) && !req);
    assign mem.read_data = read_data_q;

    // Byte-lane and out-of-range address bits have no meaning for this memory.
    assign unused_address_bits = ^{mem.address[31:19], mem.address[1:0]};
endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: a word-level memory model predicts
// loads, and a cycle-timing model predicts the SRAM bus and ready pattern.
module tb_sram_controller;
    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst;
    tri1  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe;
    logic [15:0] sram [0:262143];
    logic [17:0] wr_last;
    int          wr_run;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_words [int];
    logic [31:0] exp_rd;

    sram_controller_if mem_bus ();

    sram_controller #(.PHASE_CYCLES(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (mem_bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM device: drives reads only while the bench enables it; a write is
    // committed only once the same address has been held for a full phase.
    assign sram_dq = (sram_oe && sram_we_n) ? sram[sram_addr] : 16'bz;

    always @(posedge clk) begin
        if (!sram_we_n) begin
            if (sram_addr == wr_last && wr_run != 0) begin
                if (wr_run + 1 == P) sram[sram_addr] <= sram_dq;
                wr_run <= wr_run + 1;
            end else begin
                if (P == 1) sram[sram_addr] <= sram_dq;
                wr_run <= 1;
            end
            wr_last <= sram_addr;
        end else begin
            wr_run <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] lookupWord(input logic [16:0] w);
        if (exp_words.exists(int'(w))) return exp_words[int'(w)];
        return 32'h0;
    endfunction

    // One complete access: request shown in IDLE at cycle 0, LOW in 1..P,
    // HIGH in P+1..2P, DONE at 2P+1. With hold set the request stays up.
    task automatic applyStimulus(input bit we, input bit re, input logic [31:0] addr,
                                 input logic [31:0] data, input bit hold);
        logic [16:0] w;
        bit          hi;
        w = addr[18:2];
        @(negedge clk);
        mem_bus.wr_en      = we;
        mem_bus.rd_en      = re;
        mem_bus.address    = addr;
        mem_bus.write_data = data;
        sram_oe            = re && !we;
        #1;
        checkOutput("ready_req", 32'(mem_bus.ready), 32'h0);
        checkOutput("we_n_idle", 32'(sram_we_n), 32'h1);
        checkOutput("addr_idle", 32'(sram_addr), 32'h0);
        if (we) checkOutput("dq_idle", 32'(sram_dq), 32'hFFFF);
        for (int k = 1; k <= 2 * P + 1; k++) begin
            @(negedge clk);
            #1;
            if (k <= 2 * P) begin
                hi = (k > P);
                checkOutput("ready_busy", 32'(mem_bus.ready), 32'h0);
                checkOutput("addr_phase", 32'(sram_addr), 32'({w, hi}));
                checkOutput("we_n_phase", 32'(sram_we_n), we ? 32'h0 : 32'h1);
                if (we) checkOutput("dq_phase", 32'(sram_dq),
                                    hi ? 32'(data[31:16]) : 32'(data[15:0]));
            end else begin
                if (we) exp_words[int'(w)] = data;
                else    exp_rd = lookupWord(w);
                checkOutput("ready_done", 32'(mem_bus.ready), 32'h1);
                checkOutput("addr_done", 32'(sram_addr), 32'h0);
                checkOutput("we_n_done", 32'(sram_we_n), 32'h1);
                checkOutput("read_data", mem_bus.read_data, exp_rd);
                if (we) checkOutput("dq_done", 32'(sram_dq), 32'hFFFF);
            end
        end
        if (!hold) begin
            mem_bus.wr_en = 1'b0;
            mem_bus.rd_en = 1'b0;
            sram_oe       = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] data;
        int          op;
        rst                = 1'b1;
        sram_oe            = 1'b0;
        wr_last            = '0;
        wr_run             = 0;
        exp_rd             = 32'h0;
        mem_bus.wr_en      = 1'b0;
        mem_bus.rd_en      = 1'b0;
        mem_bus.address    = 32'h0;
        mem_bus.write_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(mem_bus.ready), 32'h1);
        checkOutput("rst_we_n", 32'(sram_we_n), 32'h1);
        checkOutput("rst_addr", 32'(sram_addr), 32'h0);
        checkOutput("rst_read_data", mem_bus.read_data, 32'h0);
        checkOutput("rst_dq", 32'(sram_dq), 32'hFFFF);

        applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0);
        checkOutput("sram_lo_82", 32'(sram[18'h82]), 32'h0000_BEEF);
        checkOutput("sram_hi_83", 32'(sram[18'h83]), 32'h0000_DEAD);
        applyStimulus(1'b0, 1'b1, 32'h0000_0104, 32'h0, 1'b0);

        // Both enables asserted behaves as a write and leaves read_data alone.
        applyStimulus(1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0104, 32'h0, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'h0000_0208, 32'hCAFE_F00D, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0104, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0208, 32'h0, 1'b0);

        // Reset during the first HIGH cycle of a write aborts the high half.
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h5A5A_1111, 1'b0);
        @(negedge clk);
        mem_bus.wr_en      = 1'b1;
        mem_bus.rd_en      = 1'b0;
        mem_bus.address    = 32'h0000_0100;
        mem_bus.write_data = 32'h7777_2222;
        repeat (P + 1) @(negedge clk);
        #1;
        checkOutput("abort_addr_high", 32'(sram_addr), 32'h0000_0081);
        rst           = 1'b1;
        mem_bus.wr_en = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abort_ready", 32'(mem_bus.ready), 32'h1);
        checkOutput("abort_we_n", 32'(sram_we_n), 32'h1);
        checkOutput("abort_addr", 32'(sram_addr), 32'h0);
        checkOutput("abort_dq", 32'(sram_dq), 32'hFFFF);
        checkOutput("abort_read_data", mem_bus.read_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_sram_lo", 32'(sram[18'h80]), 32'h0000_2222);
        checkOutput("abort_sram_hi", 32'(sram[18'h81]), 32'h0000_5A5A);
        exp_words[32'h40] = 32'h5A5A_2222;
        exp_rd            = 32'h0;
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b0);

        // Random traffic over words 0..31 with junk in the ignored address bits.
        for (int w = 0; w < 32; w++) begin
            addr = ($urandom & 32'hFFF8_0003) | (32'(w) << 2);
            applyStimulus(1'b1, 1'b0, addr, $urandom, 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 40; n++) begin
            op   = int'($urandom_range(0, 2));
            addr = ($urandom & 32'hFFF8_0003) | (32'($urandom_range(0, 31)) << 2);
            data = $urandom;
            applyStimulus(op != 1, op != 0, addr, data, 1'($urandom_range(0, 1)));
        end
        mem_bus.wr_en = 1'b0;
        mem_bus.rd_en = 1'b0;
        sram_oe       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("final_ready", 32'(mem_bus.ready), 32'h1);
        checkOutput("final_read_data", mem_bus.read_data, exp_rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
